// File: rtl/mp64_uart_ctrl_pkg.sv
// mp64_uart_ctrl_pkg: UART register map, status bit positions and controller FSM encodings.
package mp64_uart_ctrl_pkg;
  localparam logic [3:0] UART_TX      = 4'h0;
  localparam logic [3:0] UART_RX      = 4'h4;
  localparam logic [3:0] UART_STATUS  = 4'h8;
  localparam logic [3:0] UART_CONTROL = 4'hC;
  localparam int ST_TX_READY = 0;
  localparam int ST_RX_AVAIL = 1;
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_GAP    = 4'd1;
  localparam logic [3:0] S_POLL   = 4'd2;
  localparam logic [3:0] S_POLL_W = 4'd3;
  localparam logic [3:0] S_TX_WR  = 4'd4;
  localparam logic [3:0] S_TX_W   = 4'd5;
  localparam logic [3:0] S_RX_RD  = 4'd6;
  localparam logic [3:0] S_RX_W   = 4'd7;
  localparam logic [3:0] S_CFG_WR = 4'd8;
  localparam logic [3:0] S_CFG_W  = 4'd9;
endpackage

// File: rtl/mp64_uart_ctrl.sv
// mp64_uart_ctrl: polls a UART over MMIO, feeds it from two round-robin TX sources,
// drains received bytes to a sink and issues CONTROL writes on request.
module mp64_uart_ctrl
  import mp64_uart_ctrl_pkg::*;
#(
  parameter int POLL_GAP    = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  output logic       s1_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       cfg_we,
  input  logic [7:0] cfg_data,
  output logic       u_req,
  output logic       u_wen,
  output logic [3:0] u_addr,
  output logic [7:0] u_wdata,
  input  logic [7:0] u_rdata,
  input  logic       u_ack,
  output logic       busy,
  output logic       err,
  input  logic       err_clr
);
  logic [3:0]  r_state;
  logic [3:0]  w_next;
  logic [15:0] r_cnt;
  logic        r_cfg_pend;
  logic [7:0]  r_cfg_val;
  logic        r_last;
  logic        r_grant;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;
  logic        r_err;
  logic        w_wait;
  logic        w_to;
  logic        w_any;
  logic        w_pick;
  logic        w_cfg_pend;
  logic        w_count;
  assign w_wait = r_state == S_POLL_W || r_state == S_TX_W || r_state == S_RX_W || r_state == S_CFG_W;
  assign w_to = w_wait && !u_ack && r_cnt == 16'(ACK_TIMEOUT - 1);
  assign w_any = s0_valid | s1_valid;
  // r_last=1 means s1 was served last, so a tie goes to s0
  assign w_pick = (s0_valid & s1_valid) ? ~r_last : s1_valid;
  // a cfg_we arriving in IDLE is honoured the same cycle, ahead of any poll
  assign w_cfg_pend = r_cfg_pend | cfg_we;
  assign w_count = w_wait || r_state == S_GAP;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_cfg_pend ? S_CFG_WR : (w_any | ~r_rx_valid) ? S_POLL : S_IDLE;
      S_GAP:    w_next = (cfg_we || r_cnt == 16'(POLL_GAP - 1)) ? S_IDLE : S_GAP;
      S_POLL:   w_next = S_POLL_W;
      S_POLL_W: w_next = u_ack ? ((u_rdata[ST_RX_AVAIL] & ~r_rx_valid) ? S_RX_RD :
                                  (u_rdata[ST_TX_READY] & w_any) ? S_TX_WR : S_GAP) :
                         w_to ? S_IDLE : S_POLL_W;
      S_TX_WR:  w_next = S_TX_W;
      S_RX_RD:  w_next = S_RX_W;
      S_CFG_WR: w_next = S_CFG_W;
      S_TX_W, S_RX_W, S_CFG_W: w_next = (u_ack | w_to) ? S_IDLE : r_state;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cfg_pend <= 1'b0;
      r_cfg_val  <= '0;
      r_last     <= 1'b1;
      r_grant    <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= (w_count && w_next == r_state) ? r_cnt + 16'd1 : '0;
      r_cfg_pend <= cfg_we | (r_cfg_pend & ~(r_state == S_CFG_W && u_ack));
      r_rx_valid <= (r_state == S_RX_W && u_ack) | (r_rx_valid & ~rx_ready);
      r_err      <= w_to | (r_err & ~err_clr);
      if (cfg_we) r_cfg_val <= cfg_data;
      if (r_state == S_POLL_W && u_ack) r_grant <= w_pick;
      if (r_state == S_TX_WR) r_last <= r_grant;
      if (r_state == S_RX_W && u_ack) r_rx_data <= u_rdata;
    end
  end
  assign u_req = r_state == S_POLL || r_state == S_TX_WR || r_state == S_RX_RD || r_state == S_CFG_WR;
  assign u_wen = r_state == S_TX_WR || r_state == S_CFG_WR;
  assign u_addr = r_state == S_POLL   ? UART_STATUS :
                  r_state == S_TX_WR  ? UART_TX :
                  r_state == S_RX_RD  ? UART_RX :
                  r_state == S_CFG_WR ? UART_CONTROL : 4'h0;
  assign u_wdata = r_state == S_TX_WR  ? (r_grant ? s1_data : s0_data) :
                   r_state == S_CFG_WR ? r_cfg_val : 8'h00;
  assign s0_ready = r_state == S_TX_WR && !r_grant;
  assign s1_ready = r_state == S_TX_WR && r_grant;
  assign busy = !(r_state == S_IDLE || r_state == S_GAP);
  assign rx_valid = r_rx_valid;
  assign rx_data = r_rx_data;
  assign err = r_err;
endmodule

// File: tb/tb_mp64_uart_ctrl.sv
// tb_mp64_uart_ctrl: UART responder model, source drivers and an ordered scoreboard of
// expected MMIO transactions checked by an independent monitor.
module tb_mp64_uart_ctrl;
  import mp64_uart_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s0_valid = 1'b0, s1_valid = 1'b0, s0_ready, s1_ready;
  logic [7:0] s0_data = '0, s1_data = '0;
  logic rx_valid, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic cfg_we = 1'b0;
  logic [7:0] cfg_data = '0;
  logic u_req, u_wen, u_ack = 1'b0;
  logic [3:0] u_addr;
  logic [7:0] u_wdata, u_rdata = '0;
  logic busy, err, err_clr = 1'b0;

  mp64_uart_ctrl #(.POLL_GAP(8), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .cfg_we(cfg_we), .cfg_data(cfg_data),
    .u_req(u_req), .u_wen(u_wen), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_rdata(u_rdata), .u_ack(u_ack),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] addr;
    logic       wen;
    logic [7:0] data;
    logic [1:0] src;
  } txn_t;

  int checks = 0, errors = 0, cyc = 0;
  txn_t exp_q[$];
  logic [7:0] q0[$], q1[$];
  int poll_t[$];
  int poll_cnt = 0, polls_at_cfg = -1;
  logic [7:0] status_val = 8'h01, rx_byte = 8'h00;
  int ack_lat = 1;
  bit model_last = 1'b1;
  logic [3:0] m_addr;
  bit d_t0, d_t1;
  txn_t got, want;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input logic [3:0] a, input logic w, input logic [7:0] d, input logic [1:0] s);
    txn_t t;
    t.addr = a; t.wen = w; t.data = d; t.src = s;
    return t;
  endfunction

  // expected TX order: alternate while both sources hold bytes, then drain the longer one
  task automatic push_tx(input int n0, input int n1, input bit fixed);
    logic [7:0] a[$], b[$];
    int ia = 0, ib = 0;
    bit s;
    for (int i = 0; i < n0; i++) a.push_back(fixed ? 8'h10 : 8'($urandom));
    for (int i = 0; i < n1; i++) b.push_back(fixed ? 8'h20 : 8'($urandom));
    while (ia < n0 || ib < n1) begin
      s = (ia < n0 && ib < n1) ? !model_last : (ib < n1);
      if (s) begin exp_q.push_back(mk(UART_TX, 1'b1, b[ib], 2'b10)); ib++; end
      else begin exp_q.push_back(mk(UART_TX, 1'b1, a[ia], 2'b01)); ia++; end
      model_last = s;
    end
    foreach (a[i]) q0.push_back(a[i]);
    foreach (b[i]) q1.push_back(b[i]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin @(negedge clk); n++; end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    @(negedge clk);
    model_last = 1'b1;
  endtask

  task automatic release_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      d_t0 = s0_ready; d_t1 = s1_ready;
      @(posedge clk);
      #1;
      if (d_t0 && q0.size() > 0) void'(q0.pop_front());
      if (d_t1 && q1.size() > 0) void'(q1.pop_front());
      s0_valid = q0.size() > 0;
      s1_valid = q1.size() > 0;
      s0_data = 8'h00; s1_data = 8'h00;
      if (s0_valid) s0_data = q0[0];
      if (s1_valid) s1_data = q1[0];
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && u_req && ack_lat > 0) begin
        m_addr = u_addr;
        @(posedge clk);
        repeat (ack_lat - 1) @(posedge clk);
        #1;
        u_ack = 1'b1;
        u_rdata = m_addr == UART_STATUS ? status_val : m_addr == UART_RX ? rx_byte : 8'h00;
        @(posedge clk);
        #1;
        u_ack = 1'b0; u_rdata = 8'h00;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (u_req && !u_wen && u_addr == UART_STATUS) begin
          poll_cnt++;
          poll_t.push_back(cyc);
        end else if (u_req) begin
          got = mk(u_addr, u_wen, u_wdata, {s1_ready, s0_ready});
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_txn: got 0x%0h expected none at cycle %0d", got, cyc);
          end else begin
            want = exp_q.pop_front();
            if (want.addr == UART_CONTROL) polls_at_cfg = poll_cnt;
            chk("mmio_txn", int'(got), int'(want));
          end
        end
        if (!(u_req && u_wen && u_addr == UART_TX) && (s0_ready || s1_ready)) begin
          checks++; errors++;
          $display("FAIL stray_ready: got %0b%0b expected 00 at cycle %0d", s1_ready, s0_ready, cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0, n;
    logic [7:0] v;
    repeat (3) @(negedge clk);
    chk("rst_bus", {u_req, u_wen, u_addr, u_wdata}, 0);
    chk("rst_ready", {s1_ready, s0_ready}, 0);
    chk("rst_rx", {rx_valid, rx_data}, 0);
    chk("rst_err_busy", {err, busy}, 0);

    hold_reset();
    status_val = 8'h01; ack_lat = 1;
    exp_q.push_back(mk(UART_TX, 1'b1, 8'h41, 2'b01));
    q0.push_back(8'h41);
    model_last = 1'b0;
    release_reset();
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!s0_ready && lat < 20);
    chk("s0_latency", lat, 3);
    chk("first_poll_count", poll_cnt, 1);
    wait_drain();

    hold_reset();
    push_tx(2, 2, 1'b1);
    release_reset();
    wait_drain();
    for (int r = 0; r < 5; r++) begin
      ack_lat = $urandom_range(1, 3);
      push_tx($urandom_range(0, 4), $urandom_range(1, 4), 1'b0);
      wait_drain();
    end
    ack_lat = 1;

    for (int r = 0; r < 3; r++) begin
      hold_reset();
      status_val = 8'h03; rx_byte = (r == 0) ? 8'h5A : 8'($urandom);
      exp_q.push_back(mk(UART_RX, 1'b0, 8'h00, 2'b00));
      push_tx(1, 0, 1'b0);
      release_reset();
      wait_drain();
      repeat (4) @(negedge clk);
      chk("rx_valid_held", rx_valid, 1);
      chk("rx_data", rx_data, rx_byte);
      chk("idle_with_rx_held", busy, 0);
      status_val = 8'h01;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      chk("rx_drained", rx_valid, 0);
    end

    hold_reset();
    status_val = 8'h01;
    exp_q.push_back(mk(UART_CONTROL, 1'b1, 8'h01, 2'b00));
    push_tx(1, 0, 1'b0);
    p0 = poll_cnt;
    release_reset();
    cfg_we = 1'b1; cfg_data = 8'h01;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_drain();
    chk("cfg_before_poll", polls_at_cfg, p0);

    hold_reset();
    ack_lat = 0;
    v = 8'($urandom);
    exp_q.push_back(mk(UART_CONTROL, 1'b1, v, 2'b00));
    push_tx(1, 0, 1'b0);
    release_reset();
    n = 0;
    while (!u_req && n < 20) begin @(negedge clk); n++; end
    chk("timeout_poll_seen", u_req, 1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      cfg_we = (k == 5 || k == 9);
      cfg_data = (k == 5) ? ~v : v;
    end
    chk("err_before_timeout", err, 0);
    @(negedge clk);
    chk("err_at_timeout", err, 1);
    chk("idle_after_timeout", busy, 0);
    ack_lat = 1;
    wait_drain();
    chk("err_sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", err, 0);

    hold_reset();
    status_val = 8'h00;
    q0.push_back(8'h77);
    release_reset();
    poll_t.delete();
    n = 0;
    while (poll_t.size() < 3 && n < 200) begin @(negedge clk); n++; end
    chk("gap_polls_seen", poll_t.size() >= 3, 1);
    if (poll_t.size() >= 3) begin
      chk("poll_interval_a", poll_t[1] - poll_t[0], 11);
      chk("poll_interval_b", poll_t[2] - poll_t[1], 11);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!u_req && n < 40);
    #1 rst_n = 1'b0;
    #1;
    chk("midpoll_rst_bus", {u_req, u_wen, u_addr, u_wdata}, 0);
    chk("midpoll_rst_misc", {s1_ready, s0_ready, busy, err, rx_valid}, 0);
    status_val = 8'h01;
    repeat (3) begin
      @(negedge clk);
      chk("ready_in_reset", {s1_ready, s0_ready}, 0);
    end
    q0.delete();
    release_reset();
    repeat (30) @(negedge clk);
    chk("no_leftover_expect", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
